// File: rtl/fpu_rs_scheduler.sv
// FPU reservation-station issue scheduler.
// Age-matrix oldest-first select, writeback wakeup, fcsr serialisation.
module fpu_rs_scheduler #(
  parameter int DP    = 8,
  parameter int PHY_W = 6,
  parameter int TAG_W = 6,
  localparam int CW   = $clog2(DP+1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_0_valid,
  output logic             enq_0_ready,
  input  logic [TAG_W-1:0] enq_0_tag,
  input  logic             enq_0_csr,
  input  logic [PHY_W-1:0] enq_0_rd0,
  input  logic [PHY_W-1:0] enq_0_rs1,
  input  logic [PHY_W-1:0] enq_0_rs2,
  input  logic [PHY_W-1:0] enq_0_rs3,
  input  logic [2:0]       enq_0_rs_rdy,
  input  logic             enq_1_valid,
  output logic             enq_1_ready,
  input  logic [TAG_W-1:0] enq_1_tag,
  input  logic             enq_1_csr,
  input  logic [PHY_W-1:0] enq_1_rd0,
  input  logic [PHY_W-1:0] enq_1_rs1,
  input  logic [PHY_W-1:0] enq_1_rs2,
  input  logic [PHY_W-1:0] enq_1_rs3,
  input  logic [2:0]       enq_1_rs_rdy,
  input  logic             wb_0_valid,
  input  logic [PHY_W-1:0] wb_0_rd,
  input  logic             wb_1_valid,
  input  logic [PHY_W-1:0] wb_1_rd,
  input  logic             wb_2_valid,
  input  logic [PHY_W-1:0] wb_2_rd,
  output logic             deq_0_valid,
  input  logic             deq_0_ready,
  output logic [TAG_W-1:0] deq_0_tag,
  output logic [PHY_W-1:0] deq_0_rd0,
  output logic [PHY_W-1:0] deq_0_rs1,
  output logic [PHY_W-1:0] deq_0_rs2,
  output logic [PHY_W-1:0] deq_0_rs3,
  output logic             deq_1_valid,
  input  logic             deq_1_ready,
  output logic [TAG_W-1:0] deq_1_tag,
  output logic [PHY_W-1:0] deq_1_rd0,
  output logic [PHY_W-1:0] deq_1_rs1,
  output logic [PHY_W-1:0] deq_1_rs2,
  output logic [PHY_W-1:0] deq_1_rs3,
  input  logic             flush,
  output logic [CW-1:0]    free_cnt
);

  localparam logic [CW-1:0] DPC = CW'(DP);

  typedef struct packed {
    logic             csr;
    logic [TAG_W-1:0] tag;
    logic [PHY_W-1:0] rd0;
    logic [PHY_W-1:0] rs1;
    logic [PHY_W-1:0] rs2;
    logic [PHY_W-1:0] rs3;
  } ent_t;

  logic [DP-1:0] valid_q, valid_d;
  ent_t          ent_q [DP];
  ent_t          ent_d [DP];
  logic [2:0]    rdy_q [DP];
  logic [2:0]    rdy_d [DP];
  logic [DP-1:0] age_q [DP];
  logic [DP-1:0] age_d [DP];
  logic [CW-1:0] cnt_q, cnt_d;

  ent_t          new0, new1, p0, p1;
  logic [2:0]    wbv;
  logic [2:0]    wk    [DP];
  logic [2:0]    wk_e0, wk_e1;
  logic [DP-1:0] elig, sel0, sel1;
  logic [DP-1:0] a0, a1, ea0, ea1;
  logic [DP-1:0] fr0, fr1;
  logic          enq0_fire, enq1_fire;
  logic          deq0_fire, deq1_fire;

  function automatic logic hit(
    input logic [PHY_W-1:0] s,
    input logic [2:0]       v,
    input logic [PHY_W-1:0] a,
    input logic [PHY_W-1:0] b,
    input logic [PHY_W-1:0] c
  );
    return (v[0] && a == s) ||
           (v[1] && b == s) ||
           (v[2] && c == s);
  endfunction

  assign wbv  = {wb_2_valid, wb_1_valid, wb_0_valid};
  assign new0 = {enq_0_csr, enq_0_tag, enq_0_rd0,
                 enq_0_rs1, enq_0_rs2, enq_0_rs3};
  assign new1 = {enq_1_csr, enq_1_tag, enq_1_rd0,
                 enq_1_rs1, enq_1_rs2, enq_1_rs3};

  assign enq_0_ready = !flush && (cnt_q != '0);
  assign enq_1_ready = !flush && (cnt_q >= CW'(2));
  assign enq0_fire   = enq_0_valid && enq_0_ready;
  assign enq1_fire   = enq_1_valid && enq_1_ready;
  assign free_cnt    = cnt_q;

  // Writeback match per stored source and per enqueuing source
  always_comb begin
    for (int i = 0; i < DP; i++) begin
      wk[i] = {hit(ent_q[i].rs3, wbv, wb_0_rd, wb_1_rd, wb_2_rd),
               hit(ent_q[i].rs2, wbv, wb_0_rd, wb_1_rd, wb_2_rd),
               hit(ent_q[i].rs1, wbv, wb_0_rd, wb_1_rd, wb_2_rd)};
    end
    wk_e0 = {hit(enq_0_rs3, wbv, wb_0_rd, wb_1_rd, wb_2_rd),
             hit(enq_0_rs2, wbv, wb_0_rd, wb_1_rd, wb_2_rd),
             hit(enq_0_rs1, wbv, wb_0_rd, wb_1_rd, wb_2_rd)};
    wk_e1 = {hit(enq_1_rs3, wbv, wb_0_rd, wb_1_rd, wb_2_rd),
             hit(enq_1_rs2, wbv, wb_0_rd, wb_1_rd, wb_2_rd),
             hit(enq_1_rs1, wbv, wb_0_rd, wb_1_rd, wb_2_rd)};
  end

  // Eligibility and oldest / second-oldest eligible pick
  always_comb begin
    logic          older;
    logic [CW-1:0] n;
    elig = '0;
    sel0 = '0;
    sel1 = '0;
    for (int i = 0; i < DP; i++) begin
      older = 1'b0;
      for (int j = 0; j < DP; j++)
        if (valid_q[j] && age_q[j][i]) older = 1'b1;
      elig[i] = valid_q[i] && (rdy_q[i] == 3'b111) &&
                (!ent_q[i].csr || !older);
    end
    for (int i = 0; i < DP; i++) begin
      n = '0;
      for (int j = 0; j < DP; j++)
        if (elig[j] && age_q[j][i]) n = n + CW'(1);
      sel0[i] = elig[i] && (n == CW'(0));
      sel1[i] = elig[i] && (n == CW'(1));
    end
  end

  // One-hot payload muxes for the two issue ports
  always_comb begin
    p0 = '0;
    p1 = '0;
    for (int i = 0; i < DP; i++) begin
      if (sel0[i]) p0 = ent_t'(p0 | ent_q[i]);
      if (sel1[i]) p1 = ent_t'(p1 | ent_q[i]);
    end
  end

  assign deq_0_valid = !flush && (|sel0);
  assign deq_1_valid = deq_0_valid && !p0.csr &&
                       (|sel1) && !p1.csr;
  assign deq_0_tag   = p0.tag;
  assign deq_0_rd0   = p0.rd0;
  assign deq_0_rs1   = p0.rs1;
  assign deq_0_rs2   = p0.rs2;
  assign deq_0_rs3   = p0.rs3;
  assign deq_1_tag   = p1.tag;
  assign deq_1_rd0   = p1.rd0;
  assign deq_1_rs1   = p1.rs1;
  assign deq_1_rs2   = p1.rs2;
  assign deq_1_rs3   = p1.rs3;
  assign deq0_fire   = deq_0_valid && deq_0_ready;
  assign deq1_fire   = deq_1_valid && deq_1_ready;
  assign fr0         = sel0 & {DP{deq0_fire}};
  assign fr1         = sel1 & {DP{deq1_fire}};

  // Lowest two free slots from the pre-edge valid mask
  always_comb begin
    logic f0, f1;
    a0 = '0;
    a1 = '0;
    f0 = 1'b0;
    f1 = 1'b0;
    for (int i = 0; i < DP; i++) begin
      if (!valid_q[i]) begin
        if (!f0) begin
          a0[i] = 1'b1;
          f0    = 1'b1;
        end else if (!f1) begin
          a1[i] = 1'b1;
          f1    = 1'b1;
        end
      end
    end
  end

  assign ea0 = a0 & {DP{enq0_fire}};
  assign ea1 = a1 & {DP{enq1_fire}};

  // Next state: wakeup, free, allocate, age update, flush
  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    rdy_d   = rdy_q;
    age_d   = age_q;
    cnt_d   = cnt_q - CW'(enq0_fire) - CW'(enq1_fire)
                    + CW'(deq0_fire) + CW'(deq1_fire);
    for (int i = 0; i < DP; i++) begin
      if (valid_q[i]) rdy_d[i] = rdy_q[i] | wk[i];
      if (fr0[i] || fr1[i]) valid_d[i] = 1'b0;
      if (ea0[i]) begin
        valid_d[i] = 1'b1;
        ent_d[i]   = new0;
        rdy_d[i]   = enq_0_rs_rdy | wk_e0;
      end else if (ea1[i]) begin
        valid_d[i] = 1'b1;
        ent_d[i]   = new1;
        rdy_d[i]   = enq_1_rs_rdy | wk_e1;
      end
    end
    for (int i = 0; i < DP; i++)
      if (ea0[i] || ea1[i]) age_d[i] = '0;
    for (int i = 0; i < DP; i++)
      if (ea0[i] || ea1[i])
        for (int j = 0; j < DP; j++)
          age_d[j][i] = valid_q[j] || (ea1[i] && ea0[j]);
    if (flush) begin
      valid_d = '0;
      cnt_d   = DPC;
      for (int i = 0; i < DP; i++) age_d[i] = '0;
    end
  end

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      cnt_q   <= DPC;
      for (int i = 0; i < DP; i++) begin
        ent_q[i] <= '0;
        rdy_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < DP; i++) begin
        ent_q[i] <= ent_d[i];
        rdy_q[i] <= rdy_d[i];
        age_q[i] <= age_d[i];
      end
    end
  end

endmodule
